adder_stream_ctrl: RTL



---
 rtl/adder_pkg.sv | 23 ++
 rtl/result_fifo.sv | 57 +++++
 rtl/adder_stream_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared widths, latencies and types for the adder stream controller.
package adder_pkg;
    localparam int DATA_W     = 64;
    localparam int SUM_W      = DATA_W + 1;
    localparam int LO_W       = 32;
    localparam int LO_LAT     = 1;
    localparam int HI_LAT     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int HOLD_D     = HI_LAT - LO_LAT;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int CRD_W      = $clog2(FIFO_DEPTH + HI_LAT + 1);

    typedef logic [SUM_W-1:0] sum_t;

    // Credits held = results already buffered plus results still in the core.
    function automatic logic [CRD_W-1:0] credits_used(input logic [CNT_W-1:0] cnt,
                                                      input logic [HI_LAT:1]  vld);
        logic [CRD_W-1:0] n;
        n = CRD_W'(cnt);
        for (int i = 1; i <= HI_LAT; i++) n = n + CRD_W'(vld[i]);
        return n;
    endfunction
endpackage

// File: rtl/result_fifo.sv
// Show-ahead FIFO with a registered head word; wrap-bit pointers for full/empty.
module result_fifo #(
    parameter  int WIDTH = 65,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count     = wr_q - rd_q;
    assign head_data = head_q;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    // The head register is reloaded with whatever will sit at the read pointer next cycle;
    // a push into an empty FIFO becomes visible one cycle later (no fall-through).
    always_comb begin
        wr_d   = wr_q + CW'(do_push);
        rd_d   = rd_q + CW'(do_pop);
        head_d = head_q;
        if (rd_d != wr_d) begin
            if (do_push && (rd_d == wr_q)) head_d = push_data;
            else                           head_d = mem_q[rd_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/adder_stream_ctrl.sv
// Valid/ready wrapper for the external two-stage adder: tracks issues through the core,
// realigns the skewed sum lanes and buffers results behind a credit check.
module adder_stream_ctrl
    import adder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    input  logic [SUM_W-1:0]  add_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum
);
    logic [HI_LAT:1] vld_q, vld_d;
    logic            rdy_q;
    logic            issue;
    logic            push;
    logic [LO_W-1:0] lo_word;
    sum_t            push_data;
    logic            fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;

    assign add_a = in_a;
    assign add_b = in_b;

    // rdy_q only holds in_ready low for the first cycle out of reset.
    assign in_ready = rdy_q && (credits_used(fifo_cnt, vld_q) < CRD_W'(FIFO_DEPTH));
    assign issue    = in_valid && in_ready;

    always_comb begin
        vld_d    = vld_q;
        vld_d[1] = issue;
        for (int i = 2; i <= HI_LAT; i++) vld_d[i] = vld_q[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            rdy_q <= 1'b1;
        end
    end

    generate
        if (HOLD_D > 0) begin : g_hold
            logic [HOLD_D-1:0][LO_W-1:0] hold_q, hold_d;

            // Each stage advances only with its own tracked operation, so lanes stay paired.
            always_comb begin
                hold_d = hold_q;
                if (vld_q[LO_LAT]) hold_d[0] = add_sum[LO_W-1:0];
                for (int j = 1; j < HOLD_D; j++)
                    if (vld_q[LO_LAT+j]) hold_d[j] = hold_q[j-1];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) hold_q <= '0;
                else       hold_q <= hold_d;
            end

            assign lo_word = hold_q[HOLD_D-1];
        end else begin : g_nohold
            assign lo_word = add_sum[LO_W-1:0];
        end
    endgenerate

    assign push      = vld_q[HI_LAT];
    assign push_data = {add_sum[SUM_W-1:LO_W], lo_word};
    assign out_valid = !fifo_empty;

    result_fifo #(
        .WIDTH (SUM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .head_data (out_sum),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full))
        else $error("result FIFO push while full");
endmodule
